muldiv_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32M multiply/divide instructions, which the single-cycle ALU does not execute.
- Receives operands and funct3 from the execute stage when the control unit flags an M-type op (funct7 = 0000001).
- Drives one shared 33-bit add/sub through iterative shift-add (multiply) or restoring division, and stalls the core until the result is ready.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_iter.sv | 57 +++++
 rtl/muldiv_ctrl.sv | 141 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    // funct3 encodings of the M-extension ops
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    // funct3[2] separates divide/remainder from multiply
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iteration datapath: one shared (XLEN+1)-bit add/sub and a 2*XLEN-bit
// accumulator. Multiply: acc = {partial_hi, multiplier}, shift-add right.
// Divide: acc = {remainder, dividend->quotient}, restoring shift-subtract left.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic              div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc
);
    logic [XLEN-1:0] opd;
    logic [XLEN:0]   x;
    logic [XLEN:0]   y;
    logic [XLEN:0]   sum;
    logic            sub;

    // Operand muxing into the single add/sub
    always_comb begin
        if (div) begin
            // shifted partial remainder minus divisor; sum[XLEN] set means borrow
            x   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
            y   = {1'b0, opd};
            sub = 1'b1;
        end else begin
            x   = {1'b0, acc[2*XLEN-1:XLEN]};
            y   = {1'b0, (acc[0] ? opd : '0)};
            sub = 1'b0;
        end
        sum = x + (y ^ {(XLEN+1){sub}}) + {{XLEN{1'b0}}, sub};
    end

    // Load on PREP, one iteration per enabled cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
            opd <= '0;
        end else if (load) begin
            acc <= {{XLEN{1'b0}}, a};
            opd <= b;
        end else if (en) begin
            if (div) begin
                if (!sum[XLEN])
                    acc <= {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                else
                    acc <= {x[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                acc <= {sum, acc[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle RV32M sequencer: sign handling, special cases, iteration
// control and result fix-up around muldiv_iter. Stalls the core meanwhile.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    state_t          state;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] a_q, b_q;
    logic            neg_res;
    logic [CNT_W-1:0] cnt;

    logic            sa, sb, signed_a, signed_b, neg_prep;
    logic            div_zero, ovf;
    logic [XLEN-1:0] a_abs, b_abs, special_res, fix_res;
    logic [2*XLEN-1:0] acc, prod_s;

    // Sign handling, special-case detection and final result selection
    always_comb begin
        sa = a_q[XLEN-1];
        sb = b_q[XLEN-1];
        // MUL is also run on magnitudes: the low half of the negated
        // magnitude product equals the low half of the signed product.
        signed_a = (f3_q == F3_MUL) || (f3_q == F3_MULH) || (f3_q == F3_MULHSU) ||
                   (f3_q == F3_DIV) || (f3_q == F3_REM);
        signed_b = (f3_q == F3_MUL) || (f3_q == F3_MULH) ||
                   (f3_q == F3_DIV) || (f3_q == F3_REM);
        a_abs = (signed_a && sa) ? -a_q : a_q;
        b_abs = (signed_b && sb) ? -b_q : b_q;
        case (f3_q)
            F3_MUL, F3_MULH, F3_DIV: neg_prep = sa ^ sb;
            F3_MULHSU, F3_REM:       neg_prep = sa;
            default:                 neg_prep = 1'b0;
        endcase
        div_zero = is_div_op(f3_q) && (b_q == '0);
        ovf = ((f3_q == F3_DIV) || (f3_q == F3_REM)) && (a_q == INT_MIN) && (b_q == ALL_ONES);
        if (div_zero)
            special_res = f3_q[1] ? a_q : ALL_ONES;
        else
            special_res = f3_q[1] ? '0 : INT_MIN;
        // The high product half must come from the full 2*XLEN negation,
        // since the borrow from the low half matters.
        prod_s = neg_res ? -acc : acc;
        case (f3_q)
            F3_MUL:                       fix_res = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_res = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            default:                      fix_res = neg_res ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        endcase
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk  (clk),
        .rst  (rst),
        .load (state == S_PREP),
        .en   (state == S_CALC),
        .div  (is_div_op(f3_q)),
        .a    (a_abs),
        .b    (b_abs),
        .acc  (acc)
    );

    // Pipeline freeze: request cycle plus all working states, released in DONE
    assign stall = ((state == S_IDLE) && start && !kill) ||
                   (state == S_PREP) || (state == S_CALC) || (state == S_FIX);

    // Sequencer FSM with registered busy/done/result
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cnt     <= '0;
            f3_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_res <= 1'b0;
        end else begin
            done <= 1'b0;
            if (kill && (state != S_IDLE)) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start && !kill) begin
                        f3_q  <= funct3;
                        a_q   <= op_a;
                        b_q   <= op_b;
                        busy  <= 1'b1;
                        state <= S_PREP;
                    end
                    S_PREP: begin
                        neg_res <= neg_prep;
                        cnt     <= CNT_W'(XLEN);
                        if (div_zero || ovf) begin
                            result <= special_res;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_CALC;
                        end
                    end
                    S_CALC: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1))
                            state <= S_FIX;
                    end
                    S_FIX: begin
                        result <= fix_res;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected result and
// done cycle; an independent monitor pops on every done pulse.
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, stall, done;
    logic [31:0] result;

    muldiv_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .busy(busy), .stall(stall), .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] res; int at; } exp_t;
    exp_t q[$];
    int errors = 0;
    int checks = 0;
    logic [31:0] last_res = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference semantics of the RV32M ops in plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f)
            3'd0: begin p = 64'(ua * ub); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Drive one start cycle; optionally record the expected completion
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_done, output int t0);
        exp_t e;
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        t0 = cyc;
        if (expect_done) begin
            e.res = ref_model(f, a, b);
            e.at  = cyc + (is_special(f, a, b) ? 2 : 35);
            q.push_back(e);
            last_res = e.res;
        end
        @(negedge clk);
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 80 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout: %0d results outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst && done) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_done: got done=1 result %h, required no done", result);
            end else begin
                e = q.pop_front();
                chk("result", result, e.res);
                chk("done_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [2:0]  f;
        logic [31:0] a, b;
        int r;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b1;

        // MUL 7 * -3 with cycle-by-cycle busy/stall checks
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFF_FFFD; start = 1'b1;
        t0 = cyc;
        q.push_back('{res: 32'hFFFF_FFEB, at: cyc + 35});
        last_res = 32'hFFFF_FFEB;
        #1;
        chk("stall_c0", {31'd0, stall}, 32'd1);
        chk("busy_c0", {31'd0, busy}, 32'd0);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k == 1) begin start = 1'b0; op_a = $urandom; op_b = $urandom; end
            chk($sformatf("busy_c%0d", k), {31'd0, busy}, (k <= 35) ? 32'd1 : 32'd0);
            chk($sformatf("stall_c%0d", k), {31'd0, stall}, (k < 35) ? 32'd1 : 32'd0);
        end
        wait_done();

        // Directed cases: mul high halves, signed/unsigned divide, special cases
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, t0); wait_done();
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, t0); wait_done();
        issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1, t0); wait_done();
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1, t0); wait_done();
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1, t0); wait_done();
        issue(3'd5, 32'd100, 32'd7, 1, t0); wait_done();
        issue(3'd7, 32'd100, 32'd7, 1, t0); wait_done();
        issue(3'd5, 32'h1234, 32'd0, 1, t0); wait_done();
        issue(3'd7, 32'h1234, 32'd0, 1, t0); wait_done();
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, t0); wait_done();
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, t0); wait_done();
        issue(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1, t0); wait_done();

        // start and kill together in IDLE: not accepted
        @(negedge clk);
        start = 1'b1; kill = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        chk("startkill_busy", {31'd0, busy}, 32'd0);

        // Kill mid-multiply, then restart at cycle 12
        issue(3'd0, 32'd12345, 32'd678, 0, t0);
        while (cyc < t0 + 10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", {31'd0, busy}, 32'd0);
        chk("kill_result", result, last_res);
        issue(3'd0, 32'd12345, 32'd678, 1, t0);
        wait_done();

        // A start while busy must not disturb the latched DIVU
        issue(3'd5, 32'd1_000_000, 32'd7, 1, t0);
        while (cyc < t0 + 5) @(negedge clk);
        start = 1'b1; funct3 = 3'd7; op_a = 32'd55; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset at cycle 20 of an operation
        issue(3'd1, 32'h8765_4321, 32'h1357_9BDF, 0, t0);
        while (cyc < t0 + 20) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b1;

        // Randomized operations, biased toward boundary operands
        for (int n = 0; n < 40; n++) begin
            f = 3'($urandom);
            a = $urandom;
            b = $urandom;
            r = $urandom_range(0, 5);
            if (r == 0) b = 32'd0;
            else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (r == 2) b = 32'($urandom_range(1, 15));
            issue(f, a, b, 1, t0);
            wait_done();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
